// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames from a small byte FIFO onto a registered TX line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between d[7] and stop.
module uart_tx #(
    parameter int CLK_FREQ   = 5000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        TX,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
    } state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, empty;
    logic [7:0]    head;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_q, tx_n, wrap;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign empty      = (count == '0);
    assign tx_ready   = (count != FULL);
    assign push       = tx_valid & tx_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != IDLE) | !empty;
    assign TX         = tx_q;
    assign wrap       = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx_q  <= tx_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    state_n = START;
                    cnt_n   = '0;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            START: begin
                cnt_n = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                cnt_n = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    shreg_n = shreg >> 1;
                    idx_n   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (idx == 3'd7) state_n = PARITY;
`else
                    if (idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_n = wrap ? '0 : cnt + 1'b1;
                if (wrap) state_n = STOP;
            end
`endif
            STOP: begin
                cnt_n = wrap ? '0 : cnt + 1'b1;
                // Pop straight into the next start bit so frames abut.
                if (wrap && !empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end else if (wrap) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // TX is registered from the next state so the line never glitches.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model compared every cycle plus literal checks.
// Honours UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx;
    localparam int B = 43;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam int FRAME_LIT = 473;
`else
    localparam int NBITS = 10;
    localparam int FRAME_LIT = 430;
`endif
    localparam int FL = NBITS * B;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TX;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx #(.CLK_FREQ(5000000), .BAUD_RATE(115200), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .TX(TX), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: queue of accepted bytes and the current frame as a cycle offset.
    logic [7:0] q[$];
    bit         m_act;
    logic [7:0] m_byte;
    int         m_pos;
    bit         m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_act = 0;
            m_pos = 0;
        end else begin
            m_push = tx_valid && (q.size() < DEPTH);
            if (m_act) begin
                if (m_pos == FL - 1) m_act = 0;
                else m_pos++;
            end
            if (!m_act && q.size() > 0) begin
                m_byte = q.pop_front();
                m_act = 1;
                m_pos = 0;
            end
            if (m_push) q.push_back(tx_data);
        end
    end

    function automatic logic model_tx();
        int b;
        if (!m_act) return 1'b1;
        b = m_pos / B;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("tx", TX, model_tx());
        check("tx_ready", tx_ready, q.size() != DEPTH);
        check("busy", busy, m_act || q.size() != 0);
        check("fifo_count", fifo_count, q.size());
    end

    task automatic send(input logic [7:0] d);
        int n = 0;
        tx_data = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) check("send_timeout", 1, 0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20000) check("idle_timeout", 1, 0);
    endtask

    // Captures one frame from an idle start and checks it against literals.
    task automatic trace_byte(input logic [7:0] d, input logic [7:0] bits,
                              input logic par_exp);
        logic trc [FL+10];
        logic bz  [FL+10];
        int low, fall;
        wait_idle();
        tx_data = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("tx_before_pop", TX, 1'b1);
        for (int i = 0; i < FL + 10; i++) begin
            @(posedge clk); #1;
            trc[i] = TX;
            bz[i] = busy;
        end
        low = 0;
        while (low < FL && trc[low] == 1'b0) low++;
        check("start_len", low, 43);
        for (int k = 0; k < 8; k++)
            check("data_bit", trc[B*(k+1) + 21], bits[k]);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", trc[B*9 + 21], par_exp);
`else
        check("parity_unused", par_exp, ^bits);
`endif
        check("stop_bit", trc[FL - 22], 1'b1);
        fall = -1;
        for (int i = 0; i < FL + 10; i++)
            if (fall < 0 && bz[i] == 1'b0) fall = i;
        check("busy_fall", fall, FRAME_LIT);
    endtask

    initial begin
        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", TX, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_tx", TX, 1'b1);

        trace_byte(8'hA5, 8'hA5, 1'b0);
`ifdef UART_TX_PARITY_EN
        trace_byte(8'h07, 8'h07, 1'b1);
        trace_byte(8'h03, 8'h03, 1'b0);
`endif

        wait_idle();
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("burst_count", fifo_count, 3'd4);
        check("burst_ready", tx_ready, 1'b0);
        send(8'h06);
        wait_idle();

        send(8'h3C);
        send(8'h11);
        send(8'h22);
        check("pre_rst_count", fifo_count, 3'd2);
        repeat (4 * B + 18) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", TX, 1'b1);
        check("midrst_count", fifo_count, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h81);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0)
                repeat ($urandom_range(100, 600)) @(posedge clk);
            else
                repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end
endmodule
